// File: rtl/sysid_probe_master.sv
// Avalon-MM master that reads sysid words 0/1 and checks them against build constants.
// Optional macro SYSID_PROBE_AUTOSTART_EN: launch one probe automatically after each reset.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1510406386,
  parameter logic [15:0] TIMEOUT_CYCLES     = 16'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_match,
  output logic        ts_match,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_ID = 3'd1;
  localparam logic [2:0] S_RD_TS = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_stall_cnt;
  logic        r_pass;
  logic        r_id_match;
  logic        r_ts_match;
  logic        r_timeout;
  logic [31:0] r_id_value;
  logic [31:0] r_ts_value;

  logic        w_launch;
  logic        w_reading;
  logic        w_accept;
  logic        w_stall;
  logic [15:0] w_stall_inc;
  logic        w_timeout_hit;

`ifdef SYSID_PROBE_AUTOSTART_EN
  logic r_auto;

  // Armed by reset, consumed on the first IDLE cycle after reset releases.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_auto <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_auto <= 1'b0;
    end
  end

  assign w_launch = start | r_auto;
`else
  assign w_launch = start;
`endif

  assign w_reading     = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign w_accept      = w_reading && !avm_waitrequest;
  assign w_stall       = w_reading && avm_waitrequest;
  assign w_stall_inc   = r_stall_cnt + 16'd1;
  // Fires on the edge that closes the TIMEOUT_CYCLES-th stall of the current read.
  assign w_timeout_hit = w_stall && (TIMEOUT_CYCLES != 16'd0) && (w_stall_inc == TIMEOUT_CYCLES);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_stall_cnt <= 16'd0;
      r_pass      <= 1'b0;
      r_id_match  <= 1'b0;
      r_ts_match  <= 1'b0;
      r_timeout   <= 1'b0;
      r_id_value  <= 32'd0;
      r_ts_value  <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_pass      <= 1'b0;
            r_id_match  <= 1'b0;
            r_ts_match  <= 1'b0;
            r_timeout   <= 1'b0;
            r_id_value  <= 32'd0;
            r_ts_value  <= 32'd0;
            r_stall_cnt <= 16'd0;
            r_state     <= S_RD_ID;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (w_accept) begin
            r_stall_cnt <= 16'd0;
            if (r_state == S_RD_ID) begin
              r_id_value <= avm_readdata;
              r_state    <= S_RD_TS;
            end else begin
              r_ts_value <= avm_readdata;
              r_state    <= S_CHECK;
            end
          end else if (w_timeout_hit) begin
            r_timeout  <= 1'b1;
            r_pass     <= 1'b0;
            r_id_match <= 1'b0;
            r_ts_match <= 1'b0;
            r_state    <= S_FIN;
          end else begin
            r_stall_cnt <= w_stall_inc;
          end
        end
        S_CHECK: begin
          r_id_match <= (r_id_value == EXPECTED_ID);
          r_ts_match <= (r_ts_value == EXPECTED_TIMESTAMP);
          r_pass     <= (r_id_value == EXPECTED_ID) && (r_ts_value == EXPECTED_TIMESTAMP);
          r_state    <= S_FIN;
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign avm_read    = w_reading;
  assign avm_address = (r_state == S_RD_TS);
  assign busy        = w_reading || (r_state == S_CHECK);
  assign done        = (r_state == S_FIN);
  assign pass        = r_pass;
  assign id_match    = r_id_match;
  assign ts_match    = r_ts_match;
  assign timeout     = r_timeout;
  assign id_value    = r_id_value;
  assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Bench for sysid_probe_master: directed probes against a small sysid slave model,
// expected results queued at stimulus time and checked by a monitor on each done pulse.
module tb_sysid_probe_master;

  localparam logic [31:0] TS = 32'd1510406386;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_match, ts_match, timeout;
  logic [31:0] id_value, ts_value;

  sysid_probe_master #(
    .EXPECTED_ID        (32'd0),
    .EXPECTED_TIMESTAMP (TS),
    .TIMEOUT_CYCLES     (16'd4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_match        (id_match),
    .ts_match        (ts_match),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Slave model: per-read stall count, or stuck waitrequest on any/only the ts read.
  logic [31:0] id_data, ts_data;
  int          stall_cfg;
  int          stall_cnt;
  logic        wr_stuck, ts_stuck;

  assign avm_readdata    = avm_address ? ts_data : id_data;
  assign avm_waitrequest = wr_stuck || (ts_stuck && avm_address) || (avm_read && (stall_cnt < stall_cfg));

  always @(posedge clock) begin
    if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
    else                               stall_cnt <= stall_cnt + 1;
  end

  typedef struct {
    int          dc;
    logic        p;
    logic        im;
    logic        tm;
    logic        to;
    logic [31:0] iv;
    logic [31:0] tv;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  logic prev_stall = 1'b0;
  logic prev_addr  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push_exp(input int dc, input logic p, input logic im, input logic tm,
                          input logic to, input logic [31:0] iv, input logic [31:0] tv);
    exp_t x;
    x.dc = dc; x.p = p; x.im = im; x.tm = tm; x.to = to; x.iv = iv; x.tv = tv;
    exp_q.push_back(x);
  endtask

  // Drives start high from cycle c for len cycles; returns at the negedge of cycle c+len.
  task automatic start_at(input int c, input int len);
    @(negedge clock);
    while (cyc + 1 < c) @(negedge clock);
    start = 1'b1;
    repeat (len) @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s_drain: got %0d pending results want 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  // Monitor: result check on each done pulse, plus address stability across stalls.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d want no done", cyc + 1);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc + 1, e.dc);
        chk("pass", {31'd0, pass}, {31'd0, e.p});
        chk("id_match", {31'd0, id_match}, {31'd0, e.im});
        chk("ts_match", {31'd0, ts_match}, {31'd0, e.tm});
        chk("timeout", {31'd0, timeout}, {31'd0, e.to});
        chk("id_value", id_value, e.iv);
        chk("ts_value", ts_value, e.tv);
        chk("busy_in_fin", {31'd0, busy}, 32'd0);
      end
    end
    if (prev_stall && avm_read) chk("addr_stable", {31'd0, avm_address}, {31'd0, prev_addr});
    prev_stall = avm_read && avm_waitrequest && !reset;
    prev_addr  = avm_address;
  end

  initial begin
    int c;
    reset     = 1'b1;
    start     = 1'b0;
    id_data   = 32'd0;
    ts_data   = TS;
    stall_cfg = 0;
    wr_stuck  = 1'b0;
    ts_stuck  = 1'b0;

    repeat (3) @(negedge clock);
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_id_value", id_value, 32'd0);
`ifdef SYSID_PROBE_AUTOSTART_EN
    push_exp(cyc + 1 + 4, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
`endif
    reset = 1'b0;
    wait_drain("autostart");

    // Nominal probe, start at cycle 10.
    push_exp(14, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    start_at(10, 1);
    chk("c11_read", {31'd0, avm_read}, 32'd1);
    chk("c11_addr", {31'd0, avm_address}, 32'd0);
    chk("c11_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("c12_read", {31'd0, avm_read}, 32'd1);
    chk("c12_addr", {31'd0, avm_address}, 32'd1);
    @(negedge clock);
    chk("c13_read", {31'd0, avm_read}, 32'd0);
    chk("c13_busy", {31'd0, busy}, 32'd1);
    wait_drain("nominal");

    // Timestamp mismatch.
    ts_data = TS + 32'd1;
    c = cyc + 3;
    push_exp(c + 4, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd1510406387);
    start_at(c, 1);
    wait_drain("ts_mismatch");

    // ID mismatch.
    id_data = 32'd5;
    ts_data = TS;
    c = cyc + 3;
    push_exp(c + 4, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5, TS);
    start_at(c, 1);
    wait_drain("id_mismatch");

    // Three stall cycles per read, one below the timeout.
    id_data   = 32'd0;
    stall_cfg = 3;
    c = cyc + 3;
    push_exp(c + 10, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    start_at(c, 1);
    repeat (2) @(negedge clock);
    chk("stall_read_held", {31'd0, avm_read}, 32'd1);
    chk("stall_addr_held", {31'd0, avm_address}, 32'd0);
    wait_drain("stall3");
    stall_cfg = 0;

    // Waitrequest stuck on the id read: abort after 4 stalls.
    wr_stuck = 1'b1;
    c = cyc + 3;
    push_exp(c + 5, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    start_at(c, 1);
    repeat (3) @(negedge clock);
    chk("to_id_read_c4", {31'd0, avm_read}, 32'd1);
    @(negedge clock);
    chk("to_id_read_drop", {31'd0, avm_read}, 32'd0);
    wait_drain("timeout_id");
    wr_stuck = 1'b0;

    // Stuck on the ts read: id value is kept.
    id_data  = 32'h1234_5678;
    ts_stuck = 1'b1;
    c = cyc + 3;
    push_exp(c + 6, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'd0);
    start_at(c, 1);
    repeat (4) @(negedge clock);
    chk("to_ts_read_c5", {31'd0, avm_read}, 32'd1);
    @(negedge clock);
    chk("to_ts_read_drop", {31'd0, avm_read}, 32'd0);
    wait_drain("timeout_ts");
    ts_stuck = 1'b0;
    id_data  = 32'd0;

    // Start held high: ignored while busy/FIN, relaunches on the next IDLE cycle.
    c = cyc + 3;
    push_exp(c + 4, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    push_exp(c + 9, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    start_at(c, 6);
    wait_drain("start_held");

    // Reset while the ts read is stalled.
    id_data   = 32'hDEAD_BEEF;
    stall_cfg = 3;
    c = cyc + 3;
    start_at(c, 1);
    repeat (4) @(negedge clock);
    chk("pre_rst_read", {31'd0, avm_read}, 32'd1);
    chk("pre_rst_addr", {31'd0, avm_address}, 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_read", {31'd0, avm_read}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_id_value", id_value, 32'd0);
    stall_cfg = 0;
    id_data   = 32'd0;
`ifdef SYSID_PROBE_AUTOSTART_EN
    push_exp(cyc + 1 + 4, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
`endif
    reset = 1'b0;
    wait_drain("post_reset_auto");

    c = cyc + 3;
    push_exp(c + 4, 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, TS);
    start_at(c, 1);
    wait_drain("post_reset");

    // Quiet period: any stray done is flagged by the monitor.
    repeat (12) @(negedge clock);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
